// File: rtl/sram_arbiter_if.sv
// Two-port SRAM arbiter bus: requester ports, response and SRAM command.
// slave = arbiter side, master = requesters plus the SRAM read-data return.
interface sram_arbiter_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11
);
  logic                  p0_req;
  logic                  p0_we;
  logic                  p0_lock;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_done;

  logic                  p1_req;
  logic                  p1_we;
  logic                  p1_lock;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_done;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  sram_rdata,
    output p0_gnt, p0_done, p1_gnt, p1_done,
    output rdata, busy,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output sram_rdata,
    input  p0_gnt, p0_done, p1_gnt, p1_done,
    input  rdata, busy,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port single-SRAM arbiter: round-robin with bounded lock bursts.
// One transaction in flight, IDLE -> ISSUE -> WAIT -> RESP per access.
module sram_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_BURST  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  sram_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  win_q, win_d;
  logic                  last_q, last_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic any_req;
  logic lock_hold;
  logic pick;

  // Winner selection: sole requester, else lock holder, else round-robin.
  always_comb begin
    any_req   = bus.p0_req | bus.p1_req;
    lock_hold = (last_q ? bus.p1_lock : bus.p0_lock) &&
                (burst_q < BW'(MAX_BURST));
    pick      = ~last_q;
    unique case (1'b1)
      (bus.p0_req && !bus.p1_req):             pick = 1'b0;
      (bus.p1_req && !bus.p0_req):             pick = 1'b1;
      (bus.p0_req && bus.p1_req && lock_hold): pick = last_q;
      default:                                 pick = ~last_q;
    endcase
  end

  // Next-state: capture the winner's command, step the access pipeline.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    burst_d = burst_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? bus.p1_we    : bus.p0_we;
          addr_d  = pick ? bus.p1_addr  : bus.p0_addr;
          wdata_d = pick ? bus.p1_wdata : bus.p0_wdata;
          if (pick != last_q)
            burst_d = BW'(1);
          else if (burst_q < BW'(MAX_BURST))
            burst_d = burst_q + BW'(1);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        if (!we_q)
          rdata_d = bus.sram_rdata;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and command registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.p0_gnt     = (state_q == ISSUE) && !win_q;
  assign bus.p1_gnt     = (state_q == ISSUE) &&  win_q;
  assign bus.p0_done    = (state_q == RESP)  && !win_q;
  assign bus.p1_done    = (state_q == RESP)  &&  win_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.sram_en    = (state_q == ISSUE);
  assign bus.sram_we    = (state_q == ISSUE) && we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.rdata      = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized self-checking bench for sram_arbiter.
// Transaction-level model: winner rule, burst count and memory image.
module tb_sram_arbiter;
  localparam int DW = 18;
  localparam int AW = 11;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  sram_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_BURST (MB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic          r_req   [2];
  logic          r_we    [2];
  logic          r_lock  [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];

  assign bus.p0_req   = r_req[0];
  assign bus.p0_we    = r_we[0];
  assign bus.p0_lock  = r_lock[0];
  assign bus.p0_addr  = r_addr[0];
  assign bus.p0_wdata = r_wdata[0];
  assign bus.p1_req   = r_req[1];
  assign bus.p1_we    = r_we[1];
  assign bus.p1_lock  = r_lock[1];
  assign bus.p1_addr  = r_addr[1];
  assign bus.p1_wdata = r_wdata[1];

  logic [DW-1:0] sram_mem [0:2**AW-1] = '{default: '0};
  logic [DW-1:0] ref_mem  [0:2**AW-1] = '{default: '0};
  logic [DW-1:0] sram_q = '0;

  // Behavioural SRAM with a registered read port.
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
      else             sram_q <= sram_mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = sram_q;

  int cyc = 0;
  // Free-running cycle count for grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int bad = 0;
  int m_last = 1;
  int m_burst = 0;
  int gnt_cyc = 0;

  function automatic int model_pick();
    bit lk;
    if (r_req[0] && !r_req[1]) return 0;
    if (r_req[1] && !r_req[0]) return 1;
    lk = r_lock[m_last] && (m_burst < MB);
    return lk ? m_last : 1 - m_last;
  endfunction

  task automatic set_port(input int p, input bit we, input bit lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_req[p]   = 1'b1;
    r_we[p]    = we;
    r_lock[p]  = lk;
    r_addr[p]  = a;
    r_wdata[p] = d;
  endtask

  task automatic rand_port(input int p, input bit lk);
    set_port(p, 1'($urandom_range(0, 1)), lk,
             AW'($urandom), DW'($urandom));
  endtask

  task automatic apply_reset();
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    m_last   = 1;
    m_burst  = 0;
  endtask

  // One full transaction from an IDLE negedge with requests driven.
  task automatic round(output int w);
    int            e;
    bit            we_w;
    logic [AW-1:0] a_w;
    logic [DW-1:0] d_w;
    logic [DW-1:0] rd_before;
    logic [DW-1:0] rd_exp;
    e = model_pick();
    w = e;
    rd_before = bus.rdata;
    @(negedge clk);
    gnt_cyc = cyc;
    vec++;
    if (bus.p0_gnt !== (e == 0) || bus.p1_gnt !== (e == 1)) begin
      bad++;
      $display("FAIL issue_gnt: p0_gnt=%0b p1_gnt=%0b, winner must be p%0d",
               bus.p0_gnt, bus.p1_gnt, e);
    end
    we_w = r_we[e];
    a_w  = r_addr[e];
    d_w  = r_wdata[e];
    vec++;
    if (bus.sram_en !== 1'b1 || bus.sram_we !== we_w ||
        bus.sram_addr !== a_w || (we_w && bus.sram_wdata !== d_w)) begin
      bad++;
      $display("FAIL issue_cmd: en=%0b we=%0b addr=%h wdata=%h, need en=1 we=%0b addr=%h wdata=%h",
               bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata,
               we_w, a_w, d_w);
    end
    vec++;
    if (bus.busy !== 1'b1 || bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0) begin
      bad++;
      $display("FAIL issue_busy: busy=%0b done=%0b%0b, need busy=1 done=00",
               bus.busy, bus.p0_done, bus.p1_done);
    end
    if (we_w) ref_mem[a_w] = d_w;
    rd_exp = we_w ? rd_before : ref_mem[a_w];
    if (e == m_last) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
    else             m_burst = 1;
    m_last = e;
    r_req[e] = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 ||
        bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0 ||
        bus.sram_en !== 1'b0 || bus.sram_we !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL wait_out: gnt=%0b%0b done=%0b%0b en=%0b we=%0b busy=%0b, need 00 00 0 0 1",
               bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done,
               bus.sram_en, bus.sram_we, bus.busy);
    end
    @(negedge clk);
    vec++;
    if (bus.p0_done !== (e == 0) || bus.p1_done !== (e == 1) ||
        bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 ||
        bus.sram_en !== 1'b0 || bus.sram_we !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL resp_out: done=%0b%0b gnt=%0b%0b en=%0b we=%0b busy=%0b, need done for p%0d",
               bus.p0_done, bus.p1_done, bus.p0_gnt, bus.p1_gnt,
               bus.sram_en, bus.sram_we, bus.busy, e);
    end
    vec++;
    if (bus.rdata !== rd_exp) begin
      bad++;
      $display("FAIL resp_rdata: rdata=%h, need %h (we=%0b addr=%h)",
               bus.rdata, rd_exp, we_w, a_w);
    end
    @(negedge clk);
    vec++;
    if (bus.busy !== 1'b0 || bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0 ||
        bus.rdata !== rd_exp) begin
      bad++;
      $display("FAIL idle_hold: busy=%0b done=%0b%0b rdata=%h, need 0 00 %h",
               bus.busy, bus.p0_done, bus.p1_done, bus.rdata, rd_exp);
    end
  endtask

  task automatic test_reset();
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    set_port(0, 1'b0, 1'b0, 11'h005, '0);
    @(negedge clk);
    vec++;
    if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.p0_done !== 1'b0 ||
        bus.p1_done !== 1'b0 || bus.busy !== 1'b0 || bus.sram_en !== 1'b0 ||
        bus.sram_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses: gnt=%0b%0b done=%0b%0b busy=%0b en=%0b we=%0b, need all 0",
               bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done,
               bus.busy, bus.sram_en, bus.sram_we);
    end
    vec++;
    if (bus.rdata !== '0 || bus.sram_addr !== '0 || bus.sram_wdata !== '0) begin
      bad++;
      $display("FAIL reset_regs: rdata=%h addr=%h wdata=%h, need 0",
               bus.rdata, bus.sram_addr, bus.sram_wdata);
    end
    r_req[0] = 1'b0;
    reset_n = 1'b1;
    m_last = 1;
    m_burst = 0;
    @(negedge clk);
    vec++;
    if (bus.busy !== 1'b0 || bus.p0_gnt !== 1'b0 || bus.sram_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%0b gnt=%0b en=%0b, need 0 0 0",
               bus.busy, bus.p0_gnt, bus.sram_en);
    end
  endtask

  task automatic test_write_read();
    int w;
    set_port(0, 1'b1, 1'b0, 11'h020, 18'h00ABC);
    round(w);
    set_port(0, 1'b0, 1'b0, 11'h020, '0);
    round(w);
    vec++;
    if (w != 0 || bus.rdata !== 18'h00ABC) begin
      bad++;
      $display("FAIL write_read: winner=p%0d rdata=%h, need p0 00abc", w, bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int w0, w1, g0;
    apply_reset();
    set_port(0, 1'b0, 1'b0, AW'($urandom), '0);
    set_port(1, 1'b0, 1'b0, AW'($urandom), '0);
    round(w0);
    g0 = gnt_cyc;
    round(w1);
    vec++;
    if (w0 != 0 || w1 != 1 || gnt_cyc - g0 != 4) begin
      bad++;
      $display("FAIL back_to_back: order p%0d,p%0d gap=%0d, need p0,p1 gap 4",
               w0, w1, gnt_cyc - g0);
    end
  endtask

  task automatic test_alternate();
    int w;
    for (int i = 0; i < 8; i++) begin
      if (!r_req[0]) rand_port(0, 1'b0);
      if (!r_req[1]) rand_port(1, 1'b0);
      round(w);
      vec++;
      if (w != i % 2) begin
        bad++;
        $display("FAIL alternate[%0d]: winner p%0d, need p%0d", i, w, i % 2);
      end
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
  endtask

  task automatic test_lock();
    int w;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      if (!r_req[0]) rand_port(0, 1'b0);
      if (!r_req[1]) rand_port(1, 1'b1);
      round(w);
      vec++;
      if (w != ((i < 16) ? 1 : 0)) begin
        bad++;
        $display("FAIL lock[%0d]: winner p%0d, need p%0d", i, w, (i < 16) ? 1 : 0);
      end
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    r_lock[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    set_port(1, 1'b0, 1'b0, AW'($urandom), '0);
    @(negedge clk);
    vec++;
    if (bus.p1_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt: p1_gnt=%0b, need 1", bus.p1_gnt);
    end
    r_req[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++;
      if (bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0 || bus.busy !== 1'b0 ||
          bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.sram_en !== 1'b0 ||
          bus.rdata !== '0) begin
        bad++;
        $display("FAIL mid_reset[%0d]: done=%0b%0b busy=%0b gnt=%0b%0b en=%0b rdata=%h, need all 0",
                 i, bus.p0_done, bus.p1_done, bus.busy, bus.p0_gnt,
                 bus.p1_gnt, bus.sram_en, bus.rdata);
      end
    end
    reset_n = 1'b1;
    m_last = 1;
    m_burst = 0;
    set_port(0, 1'b0, 1'b0, AW'($urandom), '0);
    set_port(1, 1'b0, 1'b0, AW'($urandom), '0);
    round(w);
    vec++;
    if (w != 0) begin
      bad++;
      $display("FAIL mid_next: winner p%0d, need p0", w);
    end
    round(w);
  endtask

  task automatic test_single_write();
    int            w;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd = bus.rdata;
    a  = AW'($urandom);
    d  = DW'($urandom);
    set_port(1, 1'b1, 1'b0, a, d);
    round(w);
    vec++;
    if (w != 1 || bus.rdata !== rd) begin
      bad++;
      $display("FAIL single_write: winner p%0d rdata=%h, need p1 %h", w, bus.rdata, rd);
    end
    set_port(0, 1'b0, 1'b0, a, '0);
    round(w);
    vec++;
    if (bus.rdata !== d) begin
      bad++;
      $display("FAIL write_readback: rdata=%h, need %h", bus.rdata, d);
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p] && $urandom_range(0, 2) != 0)
          rand_port(p, 1'b0);
        r_lock[p] = 1'($urandom_range(0, 3) != 0);
      end
      if (!r_req[0] && !r_req[1]) rand_port(0, 1'b0);
      round(w);
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      r_req[p]   = 1'b0;
      r_we[p]    = 1'b0;
      r_lock[p]  = 1'b0;
      r_addr[p]  = '0;
      r_wdata[p] = '0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alternate();
    test_lock();
    test_reset_mid();
    test_single_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
